// File: rtl/pulse_monitor.sv
// Pulse monitor: measures high pulses on d_in and queues {timestamp, width}
// records in a small FIFO behind a valid/ready port.
module pulse_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int TS_W        = 16,
  parameter int WID_W       = 8,
  parameter int DEPTH       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             d_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [TS_W-1:0]  ev_time,
  output logic [WID_W-1:0] ev_width,
  output logic             overflow,
  output logic [7:0]       drop_cnt,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WID_W-1:0] WMAX = '1;

  typedef struct packed {
    logic [TS_W-1:0]  t;
    logic [WID_W-1:0] w;
  } rec_t;

  typedef enum logic {
    IDLE,
    HIGH
  } state_t;

  logic             s;
  state_t           state;
  logic             need_low;
  logic [TS_W-1:0]  timer;
  logic [TS_W-1:0]  ts;
  logic [WID_W-1:0] wcnt;

  logic             push;
  logic             pop;
  logic             wr_en;
  logic             drop;
  logic             full;
  logic             empty;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  rec_t             mem [DEPTH];
  rec_t             rd_rec;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = d_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sq;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sq <= '0;
        end else begin
          sq[0] <= d_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sq[i] <= sq[i-1];
          end
        end
      end
      assign s = sq[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // need_low blocks logging of a pulse already high at reset/clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ts       <= '0;
      wcnt     <= '0;
      need_low <= 1'b1;
    end else if (clear) begin
      state    <= IDLE;
      wcnt     <= '0;
      need_low <= 1'b1;
    end else begin
      if (!s) begin
        need_low <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (s && !need_low) begin
            ts    <= timer;
            wcnt  <= WID_W'(1);
            state <= HIGH;
          end
        end
        HIGH: begin
          if (s) begin
            if (wcnt != WMAX) begin
              wcnt <= wcnt + 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == HIGH);
  assign push  = (state == HIGH) && !s && !clear;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && ev_ready && !clear;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // a full FIFO may accept a push only into the slot being popped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {ts, wcnt};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign rd_rec   = mem[rd_ptr[AW-1:0]];
  assign ev_valid = !empty;
  assign ev_time  = rd_rec.t;
  assign ev_width = rd_rec.w;

endmodule

// File: tb/tb_pulse_monitor.sv
// Bench for pulse_monitor: directed scenarios plus randomized traffic
// compared against a pulse-run model of the monitored line.
module tb_pulse_monitor;

  localparam int SYNC  = 2;
  localparam int TS_W  = 16;
  localparam int WID_W = 8;
  localparam int DEPTH = 4;
  localparam int WMAX  = (1 << WID_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear = 1'b0;
  logic             d_in = 1'b0;
  logic             ev_ready = 1'b0;
  logic             ev_valid;
  logic [TS_W-1:0]  ev_time;
  logic [WID_W-1:0] ev_width;
  logic             overflow;
  logic [7:0]       drop_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;

  pulse_monitor #(
    .SYNC_STAGES(SYNC),
    .TS_W(TS_W),
    .WID_W(WID_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clear(clear),
    .d_in(d_in),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_time(ev_time),
    .ev_width(ev_width),
    .overflow(overflow),
    .drop_cnt(drop_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TS_W-1:0]  t;
    logic [WID_W-1:0] w;
  } rec_t;

  // model: the line is a sequence of high runs; each logged run becomes a record
  rec_t mq[$];
  bit   mdq[$];
  int   m_timer;
  bit   m_ovf;
  int   m_drops;
  bit   m_run;
  int   m_ts;
  int   m_len;
  bit   m_seen_low;

  function automatic void m_reset();
    mdq.delete();
    repeat (SYNC) mdq.push_back(1'b0);
    mq.delete();
    m_timer    = 0;
    m_ovf      = 0;
    m_drops    = 0;
    m_run      = 0;
    m_ts       = 0;
    m_len      = 0;
    m_seen_low = 0;
  endfunction

  function automatic void m_step(bit d, bit clr, bit rdy);
    bit   s;
    bit   ended;
    bit   popping;
    rec_t r;
    mdq.push_back(d);
    s = mdq.pop_front();
    if (clr) begin
      mq.delete();
      m_ovf      = 0;
      m_drops    = 0;
      m_run      = 0;
      m_seen_low = 0;
      m_timer    = 0;
      return;
    end
    ended   = 0;
    popping = (mq.size() > 0) && rdy;
    if (m_run) begin
      if (s) m_len++;
      else begin
        ended = 1;
        m_run = 0;
      end
    end else if (s && m_seen_low) begin
      m_run = 1;
      m_ts  = m_timer;
      m_len = 1;
    end
    if (!s) m_seen_low = 1;
    if (popping) void'(mq.pop_front());
    if (ended) begin
      r.t = m_ts[TS_W-1:0];
      r.w = (m_len > WMAX) ? WMAX[WID_W-1:0] : m_len[WID_W-1:0];
      if (mq.size() < DEPTH) mq.push_back(r);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    m_timer = (m_timer + 1) % (1 << TS_W);
  endfunction

  task automatic tick(input logic d, input logic clr, input logic rdy);
    d_in     = d;
    clear    = clr;
    ev_ready = rdy;
    m_step(d, clr, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b want 0", ev_valid);
    end
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_ovf got %0b/%0d want 0/0", overflow, drop_cnt);
    end
    checks++;
    if (busy !== 1'b0 || ev_time !== '0 || ev_width !== '0) begin
      errors++;
      $display("FAIL reset_out got %0b/%0d/%0d want 0/0/0",
               busy, ev_time, ev_width);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_basic();
    int nvalid;
    tick(0, 1, 1);
    repeat (18) tick(0, 0, 1);
    repeat (3) tick(1, 0, 1);
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      if (ev_valid) begin
        nvalid++;
        checks++;
        if (ev_time !== 16'd20 || ev_width !== 8'd3) begin
          errors++;
          $display("FAIL basic_rec got %0d/%0d want 20/3", ev_time, ev_width);
        end
      end
      tick(0, 0, 1);
    end
    checks++;
    if (nvalid !== 1) begin
      errors++;
      $display("FAIL basic_nvalid got %0d want 1", nvalid);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_ovf got %0b want 0", overflow);
    end
  endtask

  task automatic test_saturation();
    bit found;
    repeat (300) tick(1, 0, 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL sat_busy got %0b want 1", busy);
    end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (ev_valid && !found) begin
        found = 1;
        checks++;
        if (ev_width !== WMAX[WID_W-1:0]) begin
          errors++;
          $display("FAIL sat_width got %0d want %0d", ev_width, WMAX);
        end
        if (mq.size() > 0) begin
          checks++;
          if (ev_time !== mq[0].t) begin
            errors++;
            $display("FAIL sat_time got %0d want %0d", ev_time, mq[0].t);
          end
        end
      end
      tick(0, 0, 1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL sat_record got none want 1");
    end
  endtask

  task automatic test_back_to_back();
    logic [TS_W-1:0] t0;
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 0);
    repeat (SYNC + 2) tick(0, 0, 0);
    t0 = ev_time;
    checks++;
    if (ev_valid !== 1'b1 || ev_width !== 8'd1) begin
      errors++;
      $display("FAIL b2b_first got %0b/%0d want 1/1", ev_valid, ev_width);
    end
    tick(0, 0, 1);
    checks++;
    if (ev_valid !== 1'b1 || ev_width !== 8'd2) begin
      errors++;
      $display("FAIL b2b_second got %0b/%0d want 1/2", ev_valid, ev_width);
    end
    checks++;
    if (ev_time !== t0 + 16'd2) begin
      errors++;
      $display("FAIL b2b_gap got %0d want %0d", ev_time, t0 + 16'd2);
    end
    tick(0, 0, 1);
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty got %0b want 0", ev_valid);
    end
  endtask

  task automatic test_overflow();
    logic [TS_W-1:0] prev;
    tick(0, 1, 0);
    repeat (3) tick(0, 0, 0);
    for (int p = 0; p < 6; p++) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
    end
    repeat (SYNC + 2) tick(0, 0, 0);
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL ovf_state got %0b/%0d want 1/2", overflow, drop_cnt);
    end
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ev_valid !== 1'b1 || ev_width !== 8'd1) begin
        errors++;
        $display("FAIL ovf_drain%0d got %0b/%0d want 1/1", i, ev_valid, ev_width);
      end
      if (mq.size() > 0) begin
        checks++;
        if (ev_time !== mq[0].t) begin
          errors++;
          $display("FAIL ovf_time%0d got %0d want %0d", i, ev_time, mq[0].t);
        end
      end
      if (i > 0) begin
        checks++;
        if (ev_time !== prev + 16'd3) begin
          errors++;
          $display("FAIL ovf_order%0d got %0d want %0d", i, ev_time, prev + 16'd3);
        end
      end
      prev = ev_time;
      tick(0, 0, 1);
    end
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty got %0b want 0", ev_valid);
    end
  endtask

  task automatic test_full_pop();
    int n;
    for (int p = 0; p < 4; p++) begin
      tick(1, 0, 0);
      tick(0, 0, 0);
      tick(0, 0, 0);
    end
    repeat (3) tick(0, 0, 0);
    checks++;
    if (ev_valid !== 1'b1) begin
      errors++;
      $display("FAIL fpop_filled got %0b want 1", ev_valid);
    end
    tick(1, 0, 0);
    repeat (SYNC) tick(0, 0, 0);
    tick(0, 0, 1);
    checks++;
    if (drop_cnt !== 8'd2 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fpop_drop got %0d/%0b want 2/1", drop_cnt, overflow);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (ev_valid) n++;
      tick(0, 0, 1);
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL fpop_count got %0d want 4", n);
    end
  endtask

  task automatic test_clear_mid_pulse();
    int  t;
    int  rise;
    bit  found;
    repeat (5) tick(1, 0, 1);
    tick(1, 1, 1);
    checks++;
    if (busy !== 1'b0 || ev_valid !== 1'b0 || overflow !== 1'b0 ||
        drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_state got %0b/%0b/%0b/%0d want 0/0/0/0",
               busy, ev_valid, overflow, drop_cnt);
    end
    t = 0;
    for (int i = 0; i < 11; i++) begin
      tick((i < 5) ? 1'b1 : 1'b0, 0, 1);
      t++;
      checks++;
      if (ev_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL clr_quiet%0d got %0b/%0b want 0/0", i, ev_valid, busy);
      end
    end
    rise = t;
    tick(1, 0, 1);
    tick(1, 0, 1);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (ev_valid && !found) begin
        found = 1;
        checks++;
        if (ev_width !== 8'd2 || ev_time !== 16'(rise + SYNC)) begin
          errors++;
          $display("FAIL clr_rec got %0d/%0d want %0d/2",
                   ev_time, ev_width, rise + SYNC);
        end
      end
      tick(0, 0, 1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL clr_record got none want 1");
    end
  endtask

  task automatic test_random();
    int  run;
    bit  lvl;
    bit  exp_v;
    lvl = 0;
    run = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = ($urandom_range(0, 19) == 0) ? $urandom_range(200, 300)
                                          : $urandom_range(1, 6);
      end
      run--;
      tick(lvl, ($urandom_range(0, 249) == 0), $urandom_range(0, 2) != 0);
      exp_v = (mq.size() > 0);
      checks++;
      if (ev_valid !== exp_v) begin
        errors++;
        $display("FAIL rnd_valid@%0d got %0b want %0b", c, ev_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (ev_time !== mq[0].t || ev_width !== mq[0].w) begin
          errors++;
          $display("FAIL rnd_rec@%0d got %0d/%0d want %0d/%0d",
                   c, ev_time, ev_width, mq[0].t, mq[0].w);
        end
      end
      checks++;
      if (overflow !== m_ovf || drop_cnt !== 8'(m_drops) || busy !== m_run) begin
        errors++;
        $display("FAIL rnd_stat@%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 c, overflow, drop_cnt, busy, m_ovf, m_drops, m_run);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_clear_mid_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
